// File: rtl/microwave_pkg.sv
// Shared definitions for the microwave oven controller: FSM state encodings,
// power/phase constants and small decode helpers.
package microwave_pkg;

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StSet   = 3'd1,
    StCook  = 3'd2,
    StPause = 3'd3,
    StDone  = 3'd4
  } state_e;

  localparam int unsigned POWER_MAX = 10;
  localparam int unsigned PHASE_MOD = 10;
  localparam int unsigned DIGIT_W   = 4;
  localparam int unsigned NUM_KEYS  = 10;

  // Lowest set key index wins when several keys are down together.
  function automatic logic [DIGIT_W-1:0] key_encode(input logic [NUM_KEYS-1:0] keys);
    logic [DIGIT_W-1:0] idx;
    idx = '0;
    for (int i = NUM_KEYS - 1; i >= 0; i--) begin
      if (keys[i]) idx = DIGIT_W'(i);
    end
    return idx;
  endfunction

  // Power level 0 and out-of-range selections both mean full power.
  function automatic logic [DIGIT_W-1:0] power_clamp(input logic [DIGIT_W-1:0] sel);
    logic [DIGIT_W-1:0] p;
    p = sel;
    if (sel == '0 || 32'(sel) > POWER_MAX) p = DIGIT_W'(POWER_MAX);
    return p;
  endfunction

endpackage

// File: rtl/btn_sync_edge.sv
// Two-flop synchroniser for an active-low push button followed by a
// falling-edge detector producing a single-cycle press pulse.
module btn_sync_edge (
  input  logic clk_i,
  input  logic rst_i,
  input  logic btn_ni,
  output logic fall_o
);

  logic sync1_q, sync2_q, prev_q;

  // Flops reset to the released (high) level so reset never looks like a press.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      prev_q  <= 1'b1;
    end else begin
      sync1_q <= btn_ni;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  assign fall_o = prev_q & ~sync2_q;

endmodule

// File: rtl/cook_sequencer.sv
// Microwave oven cook sequencer: keypad entry, start/stop/door handling,
// 1 Hz prescaler for the countdown timer and magnetron duty cycling.
// Optional feature: define DONE_BEEP_EN to run the prescaler in DONE and
// sound the beeper for BEEP_SECS seconds after the cook finishes.
module cook_sequencer
  import microwave_pkg::*;
#(
  parameter int unsigned CLK_HZ     = 50_000_000,
  parameter int unsigned MAX_DIGITS = 3,
  parameter int unsigned BEEP_SECS  = 3
) (
  input  logic         clock,
  input  logic         clear,
  input  logic [9:0]   keypad,
  input  logic         startn,
  input  logic         stopn,
  input  logic         door_closed,
  input  logic [3:0]   power_sel,
  input  logic         timer_zero,
  output logic         timer_load,
  output logic [3:0]   timer_digit,
  output logic         timer_clr,
  output logic         timer_en,
  output logic         tick_1hz,
  output logic         mag_on,
  output logic         done,
  output logic [2:0]   state,
  output logic         beep
);

`ifdef DONE_BEEP_EN
  localparam bit BeepEn = 1'b1;
`else
  localparam bit BeepEn = 1'b0;
`endif

  localparam int unsigned PreW  = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam int unsigned CntW  = (MAX_DIGITS > 0) ? $clog2(MAX_DIGITS + 1) : 1;
  localparam int unsigned BeepW = (BEEP_SECS > 0) ? $clog2(BEEP_SECS + 1) : 1;
  localparam logic [PreW-1:0]    PreMax   = PreW'(CLK_HZ - 1);
  localparam logic [CntW-1:0]    DigMax   = CntW'(MAX_DIGITS);
  localparam logic [BeepW-1:0]   BeepMax  = BeepW'(BEEP_SECS);
  localparam logic [DIGIT_W-1:0] PhaseTop = DIGIT_W'(PHASE_MOD - 1);

  state_e state_q, state_d;

  logic start_p, stop_p;
  logic [NUM_KEYS-1:0] key_s1_q, key_s2_q, key_prev_q;
  logic                key_new, digit_ok;
  logic [CntW-1:0]     digit_cnt_q, digit_cnt_d;
  logic [PreW-1:0]     presc_q, presc_d;
  logic                presc_run, presc_wrap, tick;
  logic [DIGIT_W-1:0]  phase_q, phase_d;
  logic [DIGIT_W-1:0]  power_q;
  logic [BeepW-1:0]    beep_cnt_q, beep_cnt_d;
  logic                clr_d, start_cook;
  logic                timer_load_q, timer_clr_q;
  logic [DIGIT_W-1:0]  timer_digit_q;

  btn_sync_edge u_start_sync (
    .clk_i  (clock),
    .rst_i  (clear),
    .btn_ni (startn),
    .fall_o (start_p)
  );

  btn_sync_edge u_stop_sync (
    .clk_i  (clock),
    .rst_i  (clear),
    .btn_ni (stopn),
    .fall_o (stop_p)
  );

  // Keypad synchroniser plus previous-sample register for press detection.
  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      key_s1_q   <= '0;
      key_s2_q   <= '0;
      key_prev_q <= '0;
    end else begin
      key_s1_q   <= keypad;
      key_s2_q   <= key_s1_q;
      key_prev_q <= key_s2_q;
    end
  end

  assign key_new  = (key_s2_q != '0) && (key_prev_q == '0);
  // A stop in SET cancels the entry, so a digit landing in that cycle is dropped.
  assign digit_ok = key_new && (state_q == StIdle || state_q == StSet) &&
                    (digit_cnt_q < DigMax) && !stop_p;

  // Next-state logic; stop outranks start, timer_zero outranks everything in COOK.
  always_comb begin
    state_d    = state_q;
    clr_d      = 1'b0;
    start_cook = 1'b0;
    case (state_q)
      StIdle: begin
        if (digit_ok) state_d = StSet;
      end
      StSet: begin
        if (stop_p) begin
          state_d = StIdle;
          clr_d   = 1'b1;
        end else if (start_p && door_closed) begin
          state_d    = StCook;
          start_cook = 1'b1;
        end
      end
      StCook: begin
        if (timer_zero)                  state_d = StDone;
        else if (stop_p || !door_closed) state_d = StPause;
      end
      StPause: begin
        if (stop_p) begin
          state_d = StIdle;
          clr_d   = 1'b1;
        end else if (start_p && door_closed) begin
          state_d = StCook;
        end
      end
      StDone: begin
        if (stop_p || !door_closed || start_p) begin
          state_d = StIdle;
          clr_d   = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Datapath next-state: digit count, prescaler, duty phase and beep count.
  always_comb begin
    digit_cnt_d = digit_cnt_q;
    if (state_d == StIdle)   digit_cnt_d = '0;
    else if (digit_ok)       digit_cnt_d = digit_cnt_q + CntW'(1);

    presc_run  = (state_q == StCook) || (BeepEn && state_q == StDone);
    presc_wrap = (presc_q == PreMax);
    tick       = presc_run && presc_wrap;
    presc_d    = '0;
    if (presc_run)                presc_d = presc_wrap ? '0 : presc_q + PreW'(1);
    else if (state_q == StPause)  presc_d = presc_q;

    phase_d = phase_q;
    if (start_cook)                          phase_d = '0;
    else if (tick && state_q == StCook)      phase_d = (phase_q == PhaseTop) ? '0 :
                                                       phase_q + DIGIT_W'(1);

    beep_cnt_d = '0;
    if (BeepEn && state_q == StDone) begin
      beep_cnt_d = beep_cnt_q;
      if (tick && beep_cnt_q < BeepMax) beep_cnt_d = beep_cnt_q + BeepW'(1);
    end
  end

  // State and datapath registers.
  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      state_q     <= StIdle;
      digit_cnt_q <= '0;
      presc_q     <= '0;
      phase_q     <= '0;
      power_q     <= '0;
      beep_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      digit_cnt_q <= digit_cnt_d;
      presc_q     <= presc_d;
      phase_q     <= phase_d;
      beep_cnt_q  <= beep_cnt_d;
      if (start_cook) power_q <= power_clamp(power_sel);
    end
  end

  // Registered timer strobes, one cycle behind the decision that caused them.
  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      timer_load_q  <= 1'b0;
      timer_digit_q <= '0;
      timer_clr_q   <= 1'b0;
    end else begin
      timer_load_q <= digit_ok;
      timer_clr_q  <= clr_d;
      if (digit_ok) timer_digit_q <= key_encode(key_s2_q);
    end
  end

  assign timer_load  = timer_load_q;
  assign timer_digit = timer_digit_q;
  assign timer_clr   = timer_clr_q;
  assign timer_en    = (state_q == StCook);
  assign tick_1hz    = tick;
  // Door gates the magnetron combinationally so it drops the instant the door opens.
  assign mag_on      = (state_q == StCook) && door_closed && (phase_q < power_q);
  assign done        = (state_q == StDone);
  assign state       = state_q;
  assign beep        = BeepEn && (state_q == StDone) && (beep_cnt_q < BeepMax);

endmodule

// File: tb/tb_cook_sequencer.sv
// Directed bench for cook_sequencer with a 10 Hz "clock" so one second is ten cycles.
module tb_cook_sequencer;

  logic       clock = 1'b0;
  logic       clear;
  logic [9:0] keypad;
  logic       startn, stopn, door_closed, timer_zero;
  logic [3:0] power_sel;
  logic       timer_load, timer_clr, timer_en, tick_1hz, mag_on, done, beep;
  logic [3:0] timer_digit;
  logic [2:0] state;

  int n_checks = 0;
  int n_fail   = 0;

  cook_sequencer #(
    .CLK_HZ     (10),
    .MAX_DIGITS (3),
    .BEEP_SECS  (3)
  ) dut (
    .clock       (clock),
    .clear       (clear),
    .keypad      (keypad),
    .startn      (startn),
    .stopn       (stopn),
    .door_closed (door_closed),
    .power_sel   (power_sel),
    .timer_zero  (timer_zero),
    .timer_load  (timer_load),
    .timer_digit (timer_digit),
    .timer_clr   (timer_clr),
    .timer_en    (timer_en),
    .tick_1hz    (tick_1hz),
    .mag_on      (mag_on),
    .done        (done),
    .state       (state),
    .beep        (beep)
  );

  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required finish before 200000");
    $fatal(1, "timeout");
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] all_outs();
    return 32'({timer_load, timer_digit, timer_clr, timer_en, tick_1hz, mag_on, done, beep});
  endfunction

  // Press a key pattern, check the load strobe three cycles later, release.
  task automatic key(input logic [9:0] k, input bit exp_load, input logic [3:0] exp_digit,
                     input string tag);
    keypad = k;
    cyc(3);
    check({tag, "_load"}, 32'(timer_load), 32'(exp_load));
    if (exp_load) check({tag, "_digit"}, 32'(timer_digit), 32'(exp_digit));
    keypad = '0;
    cyc(1);
    check({tag, "_load_pulse"}, 32'(timer_load), 0);
    cyc(2);
  endtask

  // Start-button press: state changes three cycles after the button falls.
  task automatic press_start();
    startn = 1'b0;
    cyc(3);
    startn = 1'b1;
  endtask

  task automatic press_stop();
    stopn = 1'b0;
    cyc(3);
    stopn = 1'b1;
  endtask

  // Entered at the first cycle of a fresh cook (prescaler 0, phase 0).
  task automatic cook_window(input int n, input int p, input string tag);
    for (int i = 0; i < n; i++) begin
      check({tag, "_tick"}, 32'(tick_1hz), 32'(i % 10 == 9));
      check({tag, "_mag"}, 32'(mag_on), 32'(((i / 10) % 10) < p));
      cyc(1);
    end
  endtask

  initial begin
    int ticks;
    int n;
    clear = 1'b1; keypad = '0; startn = 1'b1; stopn = 1'b1;
    door_closed = 1'b1; power_sel = 4'd10; timer_zero = 1'b0;
    cyc(2);
    check("rst_state", 32'(state), 0);
    check("rst_outputs", all_outs(), 0);
    clear = 1'b0;
    cyc(3);

    // Entry of 1, 3 (with 7 also held), 0, then a fourth digit that is ignored.
    key(10'b0000000010, 1'b1, 4'd1, "key1");
    check("set_after_key", 32'(state), 1);
    key(10'b0010001000, 1'b1, 4'd3, "key3_multi");
    key(10'b0000000001, 1'b1, 4'd0, "key0");
    check("set_mag_off", 32'(mag_on), 0);
    key(10'b0000100000, 1'b0, 4'd0, "key_fourth");
    check("set_still", 32'(state), 1);

    // Full-power cook, two seconds.
    press_start();
    check("cook_state", 32'(state), 2);
    check("cook_timer_en", 32'(timer_en), 1);
    cook_window(20, 10, "p10");

    // Timer reaches zero.
    timer_zero = 1'b1;
    cyc(1);
    timer_zero = 1'b0;
    check("done_state", 32'(state), 4);
    check("done_flag", 32'(done), 1);
    check("done_mag", 32'(mag_on), 0);
    check("done_timer_en", 32'(timer_en), 0);
`ifdef DONE_BEEP_EN
    ticks = 0;
    n = 0;
    while (n < 40 && ticks < 3) begin
      check("beep_on", 32'(beep), 1);
      if (tick_1hz) ticks++;
      n++;
      cyc(1);
    end
    check("beep_ticks", 32'(ticks), 3);
    check("beep_len", 32'(n), 29);
    check("beep_off", 32'(beep), 0);
`else
    ticks = 0;
    n = 0;
    for (int i = 0; i < 12; i++) begin
      check("done_no_tick", 32'(tick_1hz), 0);
      check("done_no_beep", 32'(beep), 0);
      cyc(1);
    end
`endif
    press_stop();
    check("done_stop_state", 32'(state), 0);
    check("done_stop_clr", 32'(timer_clr), 1);
    cyc(1);
    check("clr_pulse", 32'(timer_clr), 0);
    cyc(2);

    // Power 3: magnetron on for phases 0..2; later power_sel change must not matter.
    key(10'b0000000100, 1'b1, 4'd2, "key2");
    power_sel = 4'd3;
    press_start();
    power_sel = 4'd10;
    check("p3_state", 32'(state), 2);
    cook_window(100, 3, "p3");
    press_stop();
    check("p3_pause", 32'(state), 3);
    check("pause_mag", 32'(mag_on), 0);
    cyc(4);
    press_stop();
    check("pause_stop_state", 32'(state), 0);
    check("pause_stop_clr", 32'(timer_clr), 1);
    cyc(3);

    // Power 0 behaves as 10, then door opening mid-second.
    key(10'b0010000000, 1'b1, 4'd7, "key7");
    power_sel = 4'd0;
    press_start();
    cook_window(100, 10, "p0");
    cyc(3);
    door_closed = 1'b0;
    #1;
    check("door_mag_same_cycle", 32'(mag_on), 0);
    cyc(1);
    check("door_pause", 32'(state), 3);
    for (int i = 0; i < 6; i++) begin
      check("pause_no_tick", 32'(tick_1hz), 0);
      cyc(1);
    end
    door_closed = 1'b1;
    press_start();
    check("resume_state", 32'(state), 2);
    check("resume_mag", 32'(mag_on), 1);
    for (int i = 0; i < 6; i++) begin
      check("resume_tick", 32'(tick_1hz), 32'(i == 5));
      cyc(1);
    end

    // timer_zero and stop in the same cycle: DONE wins.
    stopn = 1'b0;
    cyc(2);
    timer_zero = 1'b1;
    cyc(1);
    timer_zero = 1'b0;
    stopn = 1'b1;
    check("zero_vs_stop", 32'(state), 4);
    cyc(2);
    check("done_holds", 32'(state), 4);
    door_closed = 1'b0;
    cyc(1);
    check("done_door_state", 32'(state), 0);
    check("done_door_clr", 32'(timer_clr), 1);
    door_closed = 1'b1;
    cyc(3);

    // Start and stop together in SET.
    key(10'b1000000000, 1'b1, 4'd9, "key9");
    startn = 1'b0;
    stopn = 1'b0;
    cyc(3);
    check("both_state", 32'(state), 0);
    check("both_clr", 32'(timer_clr), 1);
    check("both_mag", 32'(mag_on), 0);
    startn = 1'b1;
    stopn = 1'b1;
    cyc(3);

    // Start with door open is ignored; then start with 0:00 on the timer.
    key(10'b0000010000, 1'b1, 4'd4, "key4");
    door_closed = 1'b0;
    press_start();
    check("door_open_start", 32'(state), 1);
    check("door_open_mag", 32'(mag_on), 0);
    cyc(3);
    door_closed = 1'b1;
    timer_zero = 1'b1;
    press_start();
    check("zero_start_cook", 32'(state), 2);
    cyc(1);
    check("zero_start_done", 32'(state), 4);
    timer_zero = 1'b0;
    cyc(3);
    press_stop();
    check("zero_stop_idle", 32'(state), 0);
    cyc(3);

    // Asynchronous clear during a cook.
    key(10'b0000100000, 1'b1, 4'd5, "key5");
    power_sel = 4'd10;
    press_start();
    cyc(4);
    check("pre_clear_mag", 32'(mag_on), 1);
    clear = 1'b1;
    #1;
    check("clear_state", 32'(state), 0);
    check("clear_outputs", all_outs(), 0);
    cyc(2);
    clear = 1'b0;
    cyc(2);
    check("after_clear_state", 32'(state), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
